xtea_in_loader: RTL

Word-serial input stage for the XTEA encryptor. Accepts 32-bit words over a valid/ready stream and assembles them into a persistent 128-bit key and 128-bit data blocks. For each complete data block it presents the block and key to the encryptor, issues a one-cycle `start` pulse, and holds off the stream until the encryptor reports `enc_done`.

---
 rtl/xtea_pkg.sv | 16 +
 rtl/xtea_word_packer.sv | 29 ++
 rtl/xtea_in_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/xtea_pkg.sv
// Shared types and sizes for the XTEA input loader.
package xtea_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned IDX_W           = 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FIRE,
        WAIT
    } loader_state_t;

endpackage

// File: rtl/xtea_word_packer.sv
// 128-bit register written one 32-bit word at a time; word 0 lands in the MSW.
module xtea_word_packer
    import xtea_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [WORD_W-1:0]  word_i,
    output logic [BLOCK_W-1:0] block_o
);

    logic [BLOCK_W-1:0] block_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            block_q <= '0;
        end else if (we_i) begin
            for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
                if (idx_i == w[IDX_W-1:0]) begin
                    block_q[BLOCK_W-1-WORD_W*w -: WORD_W] <= word_i;
                end
            end
        end
    end

    assign block_o = block_q;

endmodule

// File: rtl/xtea_in_loader.sv
// Word-serial key/data loader for the XTEA encryptor.
// Define XTEA_LOADER_TIMEOUT_EN to abort WAIT after TIMEOUT cycles without enc_done.
module xtea_in_loader
    import xtea_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_is_key,
    input  logic               enc_done,
    output logic [BLOCK_W-1:0] key,
    output logic [BLOCK_W-1:0] data_o,
    output logic               start,
    output logic               key_valid,
    output logic               busy,
    output logic               err_nokey,
    output logic               timeout
);

    loader_state_t      state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               kind_q, kind_d;
    logic               key_valid_q, key_valid_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               start_q, start_d;
    logic               err_q, err_d;
    logic               tmo_q, tmo_d;
    logic               tmo_hit;

    logic               accept;
    logic               frame_is_key;
    logic [BLOCK_W-1:0] staging;
    logic               unused_stage_lsw;

    assign s_ready      = !reset && (state_q == IDLE || state_q == FILL);
    assign busy         = (state_q == FIRE) || (state_q == WAIT);
    assign accept       = s_valid && s_ready;
    // The frame kind is only sampled with word 0; later words use the latched kind.
    assign frame_is_key = (state_q == IDLE) ? s_is_key : kind_q;

    xtea_word_packer u_key_packer (
        .clk     (clk),
        .reset   (reset),
        .we_i    (accept && frame_is_key),
        .idx_i   (cnt_q),
        .word_i  (s_data),
        .block_o (key)
    );

    xtea_word_packer u_data_packer (
        .clk     (clk),
        .reset   (reset),
        .we_i    (accept && !frame_is_key),
        .idx_i   (cnt_q),
        .word_i  (s_data),
        .block_o (staging)
    );

    // The last word is taken straight from s_data, so the staging LSW is never read.
    assign unused_stage_lsw = ^staging[WORD_W-1:0];

`ifdef XTEA_LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d  = (state_q == WAIT) ? wcnt_q + TW'(1) : '0;
        tmo_hit = (state_q == WAIT) && (wcnt_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT != 0);
    assign tmo_hit            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = accept ? cnt_q + 2'd1 : cnt_q;
        kind_d      = kind_q;
        key_valid_d = key_valid_q;
        data_d      = data_q;
        err_d       = 1'b0;
        tmo_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    kind_d  = s_is_key;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (accept && cnt_q == 2'd3) begin
                    if (frame_is_key) begin
                        key_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else if (key_valid_q) begin
                        data_d  = {staging[BLOCK_W-1:WORD_W], s_data};
                        state_d = FIRE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            FIRE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (enc_done) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = (state_d == FIRE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            kind_q      <= 1'b0;
            key_valid_q <= 1'b0;
            data_q      <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            key_valid_q <= key_valid_d;
            data_q      <= data_d;
            start_q     <= start_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign data_o    = data_q;
    assign start     = start_q;
    assign key_valid = key_valid_q;
    assign err_nokey = err_q;
    assign timeout   = tmo_q;

endmodule
